// File: rtl/word_serializer_if.sv
// -----------------------------------------------------------------------------
// word_serializer_if
//   Handshake bundle for word_serializer: one word-wide input stream and one
//   lane-wide output stream, both valid/ready.
//
//   in_valid / in_ready   : input word handshake
//   in_data               : LANES*LANE_W-bit word, lane k = in_data[k*LANE_W +: LANE_W]
//   msb_first             : lane order for the word, sampled on acceptance
//   out_valid / out_ready : output lane handshake
//   out_data              : current lane
//   out_idx               : source lane index of out_data
//   out_last              : out_data is the final lane of the word
//
//   master : producer/consumer side (drives in_*, msb_first, out_ready)
//   slave  : serializer side
// -----------------------------------------------------------------------------
interface word_serializer_if #(
   parameter int LANE_W = 8,
   parameter int LANES  = 4,
   parameter int IDX_W  = 2
);
   logic                      in_valid;
   logic                      in_ready;
   logic [LANES*LANE_W-1:0]   in_data;
   logic                      msb_first;
   logic                      out_valid;
   logic                      out_ready;
   logic [LANE_W-1:0]         out_data;
   logic [IDX_W-1:0]          out_idx;
   logic                      out_last;

   modport master (
      output in_valid, in_data, msb_first, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_data, msb_first, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );
endinterface

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
//   Accepts one LANES*LANE_W-bit word and emits its LANE_W-bit lanes one per
//   beat, in lane-0-first or lane-(LANES-1)-first order chosen per word. The
//   final lane of each word is flagged with out_last. A new word can be taken
//   in the same cycle the last lane leaves, so streaming words have no gap.
//
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : word_serializer_if slave modport (see interface for signal list)
// -----------------------------------------------------------------------------
module word_serializer #(
   parameter int LANE_W = 8,
   parameter int LANES  = 4,
   parameter int IDX_W  = 2
) (
   input  logic               clk,
   input  logic               reset,
   word_serializer_if.slave   bus
);

   localparam int               WORD_W = LANES * LANE_W;
   localparam logic [IDX_W-1:0] LAST_B = IDX_W'(LANES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   word_q,  word_d;
   logic                msb_q,   msb_d;
   logic [IDX_W-1:0]    beat_q,  beat_d;

   logic                is_send;
   logic                is_last;
   logic                in_ready_c;
   logic [IDX_W-1:0]    idx;
   logic [WORD_W-1:0]   shifted;

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   // The word register is reset as well so out_data reads 0 after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         word_q  <= '0;
         msb_q   <= 1'b0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         msb_q   <= msb_d;
         beat_q  <= beat_d;
      end
   end

   // NOTE: every signal assigned here gets a default first; a path that
   // leaves one unassigned would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      msb_d   = msb_q;
      beat_d  = beat_q;

      is_send = (state_q == SEND);
      is_last = is_send && (beat_q == LAST_B);
      // Ready while idle, or when the final lane is leaving this cycle; the
      // latter is what lets consecutive words stream without a bubble.
      in_ready_c = !is_send || (is_last && bus.out_ready);

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = SEND;
               word_d  = bus.in_data;
               msb_d   = bus.msb_first;
               beat_d  = '0;
            end
         end
         SEND: begin
            if (bus.out_ready) begin
               if (!is_last) begin
                  beat_d = beat_q + IDX_W'(1);
               end else if (bus.in_valid) begin
                  word_d = bus.in_data;
                  msb_d  = bus.msb_first;
                  beat_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Lane selection only looks at latched state, never at in_data.
   always_comb begin
      idx     = msb_q ? (LAST_B - beat_q) : beat_q;
      shifted = word_q >> (int'(idx) * LANE_W);
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = is_send;
   assign bus.out_data  = is_send ? shifted[LANE_W-1:0] : '0;
   assign bus.out_idx   = is_send ? idx : '0;
   assign bus.out_last  = is_last;

endmodule

// File: tb/tb_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_serializer
//   Directed bench for word_serializer. Three instances share clk/reset:
//     a : LANE_W=8,  LANES=4, IDX_W=2 (main configuration)
//     b : LANE_W=4,  LANES=3, IDX_W=2 (non-power-of-two lane count)
//     c : LANE_W=32, LANES=1, IDX_W=1 (single lane, skid register)
//   Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_word_serializer;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   word_serializer_if #(.LANE_W(8),  .LANES(4), .IDX_W(2)) a_if ();
   word_serializer_if #(.LANE_W(4),  .LANES(3), .IDX_W(2)) b_if ();
   word_serializer_if #(.LANE_W(32), .LANES(1), .IDX_W(1)) c_if ();

   word_serializer #(.LANE_W(8),  .LANES(4), .IDX_W(2)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
   word_serializer #(.LANE_W(4),  .LANES(3), .IDX_W(2)) dut_b (.clk(clk), .reset(reset), .bus(b_if));
   word_serializer #(.LANE_W(32), .LANES(1), .IDX_W(1)) dut_c (.clk(clk), .reset(reset), .bus(c_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "simulation timeout");
   end

   task automatic test_reset();
      logic [11:0] got;
      @(negedge clk);
      #1;
      vectors++;
      if (a_if.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_hold out_valid: got %b want 0", a_if.out_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      got = {a_if.out_valid, a_if.out_data, a_if.out_idx, a_if.out_last};
      vectors++;
      if (got !== 12'h000) begin
         miscompares++;
         $display("FAIL reset a {valid,data,idx,last}: got %h want 000", got);
      end
      vectors++;
      if ({a_if.in_ready, b_if.in_ready, c_if.in_ready} !== 3'b111) begin
         miscompares++;
         $display("FAIL reset in_ready a/b/c: got %b want 111",
                  {a_if.in_ready, b_if.in_ready, c_if.in_ready});
      end
      vectors++;
      if ({b_if.out_valid, c_if.out_valid, c_if.out_data} !== 34'h0) begin
         miscompares++;
         $display("FAIL reset b/c outputs: got %h want 0",
                  {b_if.out_valid, c_if.out_valid, c_if.out_data});
      end
   endtask

   task automatic test_lsb_first();
      logic [7:0]  exp_d [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
      logic [12:0] got, want;
      @(negedge clk);
      a_if.in_valid  = 1'b1;
      a_if.in_data   = 32'h1234_5678;
      a_if.msb_first = 1'b0;
      a_if.out_ready = 1'b1;
      #1;
      vectors++;
      if (a_if.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL lsb idle in_ready: got %b want 1", a_if.in_ready);
      end
      @(negedge clk);
      // Changing unaccepted inputs must not disturb the word in flight.
      a_if.in_valid  = 1'b0;
      a_if.in_data   = 32'hFFFF_FFFF;
      a_if.msb_first = 1'b1;
      for (int b = 0; b < 4; b++) begin
         #1;
         got  = {a_if.out_valid, a_if.out_data, a_if.out_idx, a_if.out_last, a_if.in_ready};
         want = {1'b1, exp_d[b], 2'(b), (b == 3), (b == 3)};
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL lsb beat %0d {valid,data,idx,last,in_ready}: got %h want %h", b, got, want);
         end
         @(negedge clk);
      end
      #1;
      vectors++;
      if (a_if.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL lsb after word out_valid: got %b want 0", a_if.out_valid);
      end
   endtask

   task automatic test_msb_first();
      logic [7:0]  exp_d [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
      logic [12:0] got, want;
      @(negedge clk);
      a_if.in_valid  = 1'b1;
      a_if.in_data   = 32'h1234_5678;
      a_if.msb_first = 1'b1;
      @(negedge clk);
      a_if.in_valid  = 1'b0;
      a_if.msb_first = 1'b0;
      for (int b = 0; b < 4; b++) begin
         #1;
         got  = {a_if.out_valid, a_if.out_data, a_if.out_idx, a_if.out_last, a_if.in_ready};
         want = {1'b1, exp_d[b], 2'(3 - b), (b == 3), (b == 3)};
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL msb beat %0d {valid,data,idx,last,in_ready}: got %h want %h", b, got, want);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      logic        rdy   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [7:0]  exp_d [7] = '{8'hD4, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hB2, 8'hA1};
      logic [1:0]  exp_i [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
      logic [12:0] got, want;
      @(negedge clk);
      a_if.in_valid  = 1'b1;
      a_if.in_data   = 32'hA1B2_C3D4;
      a_if.msb_first = 1'b0;
      a_if.out_ready = 1'b1;
      @(negedge clk);
      a_if.in_valid = 1'b0;
      for (int c = 0; c < 7; c++) begin
         a_if.out_ready = rdy[c];
         #1;
         got  = {a_if.out_valid, a_if.out_data, a_if.out_idx, a_if.out_last, a_if.in_ready};
         want = {1'b1, exp_d[c], exp_i[c], (c == 6), (c == 6)};
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL backpressure cycle %0d {valid,data,idx,last,in_ready}: got %h want %h", c, got, want);
         end
         @(negedge clk);
      end
      a_if.out_ready = 1'b1;
      #1;
      vectors++;
      if (a_if.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL backpressure after word out_valid: got %b want 0", a_if.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  exp_d [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
      logic [12:0] got, want;
      @(negedge clk);
      a_if.in_valid  = 1'b1;
      a_if.in_data   = 32'h1122_3344;
      a_if.msb_first = 1'b0;
      a_if.out_ready = 1'b1;
      @(negedge clk);
      a_if.in_data = 32'h5566_7788;
      for (int c = 0; c < 8; c++) begin
         a_if.in_valid = (c < 4);
         #1;
         got  = {a_if.out_valid, a_if.out_data, a_if.out_idx, a_if.out_last, a_if.in_ready};
         want = {1'b1, exp_d[c], 2'(c % 4), (c % 4 == 3), (c % 4 == 3)};
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL back_to_back beat %0d {valid,data,idx,last,in_ready}: got %h want %h", c, got, want);
         end
         @(negedge clk);
      end
      #1;
      vectors++;
      if (a_if.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL back_to_back after words out_valid: got %b want 0", a_if.out_valid);
      end
   endtask

   task automatic test_reset_mid_word();
      logic [7:0]  exp_d [2] = '{8'hEF, 8'hBE};
      logic [7:0]  exp_n [4] = '{8'h01, 8'h00, 8'h00, 8'h00};
      logic [11:0] got, want;
      @(negedge clk);
      a_if.in_valid  = 1'b1;
      a_if.in_data   = 32'hDEAD_BEEF;
      a_if.msb_first = 1'b0;
      a_if.out_ready = 1'b1;
      @(negedge clk);
      a_if.in_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         vectors++;
         if (a_if.out_data !== exp_d[c]) begin
            miscompares++;
            $display("FAIL rst_mid beat %0d data: got %h want %h", c, a_if.out_data, exp_d[c]);
         end
         @(negedge clk);
      end
      #1;
      vectors++;
      if ({a_if.out_valid, a_if.out_data} !== 9'h1AD) begin
         miscompares++;
         $display("FAIL rst_mid third lane {valid,data}: got %h want 1ad", {a_if.out_valid, a_if.out_data});
      end
      // Assert reset between clock edges; outputs must drop without an edge.
      #1;
      reset = 1'b1;
      #1;
      got = {a_if.out_valid, a_if.out_data, a_if.out_idx, a_if.out_last};
      vectors++;
      if (got !== 12'h000) begin
         miscompares++;
         $display("FAIL rst_mid async {valid,data,idx,last}: got %h want 000", got);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if (a_if.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid release cycle %0d out_valid: got %b want 0", c, a_if.out_valid);
         end
         @(negedge clk);
      end
      a_if.in_valid = 1'b1;
      a_if.in_data  = 32'h0000_0001;
      @(negedge clk);
      a_if.in_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         #1;
         got  = {a_if.out_valid, a_if.out_data, a_if.out_idx, a_if.out_last};
         want = {1'b1, exp_n[b], 2'(b), (b == 3)};
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL rst_mid new word beat %0d {valid,data,idx,last}: got %h want %h", b, got, want);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_lanes3();
      logic [3:0] exp_d [6] = '{4'hC, 4'hB, 4'hA, 4'hA, 4'hB, 4'hC};
      logic [1:0] exp_i [6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
      logic [7:0] got, want;
      b_if.out_ready = 1'b1;
      for (int w = 0; w < 2; w++) begin
         @(negedge clk);
         b_if.in_valid  = 1'b1;
         b_if.in_data   = 12'hABC;
         b_if.msb_first = (w == 1);
         @(negedge clk);
         b_if.in_valid = 1'b0;
         for (int b = 0; b < 3; b++) begin
            #1;
            got  = {b_if.out_valid, b_if.out_data, b_if.out_idx, b_if.out_last};
            want = {1'b1, exp_d[w*3 + b], exp_i[w*3 + b], (b == 2)};
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("FAIL lanes3 word %0d beat %0d {valid,data,idx,last}: got %h want %h", w, b, got, want);
            end
            @(negedge clk);
         end
      end
      #1;
      vectors++;
      if (b_if.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL lanes3 after words out_valid: got %b want 0", b_if.out_valid);
      end
   endtask

   task automatic test_lanes1();
      logic [31:0] exp_d [3] = '{32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0123_4567};
      logic        rdy   [3] = '{1'b0, 1'b1, 1'b1};
      logic [35:0] got, want;
      @(negedge clk);
      c_if.in_valid  = 1'b1;
      c_if.in_data   = 32'hCAFE_F00D;
      c_if.msb_first = 1'b1;
      c_if.out_ready = 1'b1;
      @(negedge clk);
      c_if.in_data = 32'h0123_4567;
      for (int c = 0; c < 3; c++) begin
         c_if.in_valid  = (c < 2);
         c_if.out_ready = rdy[c];
         #1;
         got  = {c_if.out_valid, c_if.out_data, c_if.out_idx, c_if.out_last, c_if.in_ready};
         want = {1'b1, exp_d[c], 1'b0, 1'b1, rdy[c]};
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL lanes1 cycle %0d {valid,data,idx,last,in_ready}: got %h want %h", c, got, want);
         end
         @(negedge clk);
      end
      c_if.in_valid = 1'b0;
      #1;
      vectors++;
      if (c_if.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL lanes1 after words out_valid: got %b want 0", c_if.out_valid);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.msb_first = 1'b0; a_if.out_ready = 1'b1;
      b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.msb_first = 1'b0; b_if.out_ready = 1'b1;
      c_if.in_valid = 1'b0; c_if.in_data = '0; c_if.msb_first = 1'b0; c_if.out_ready = 1'b1;

      test_reset();
      test_lsb_first();
      test_msb_first();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_word();
      test_lanes3();
      test_lanes1();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
